// File: rtl/mesi_controller_pkg.sv
// Shared types for the MESI cache coherence controller: line states,
// bus commands, controller FSM states and counter indices.
package mesi_controller_pkg;

  typedef enum logic [1:0] {
    I = 2'd0,
    S = 2'd1,
    E = 2'd2,
    M = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    bus_none    = 3'd0,
    bus_read    = 3'd1,
    bus_readex  = 3'd2,
    bus_upgrade = 3'd3,
    bus_flush   = 3'd4
  } bus_cmd_t;

  typedef enum logic [2:0] {
    FSM_IDLE     = 3'd0,
    FSM_ARB_WB   = 3'd1,
    FSM_WB       = 3'd2,
    FSM_ARB_FILL = 3'd3,
    FSM_FILL     = 3'd4,
    FSM_DONE     = 3'd5
  } fsm_t;

  localparam int CNT_HIT  = 0;
  localparam int CNT_MISS = 1;
  localparam int CNT_WB   = 2;
  localparam int NUM_CNT  = 3;

endpackage

// File: rtl/mesi_controller_snoop.sv
// Registered snoop responder: computes the new state of a snooped local line
// and tells the FSM when a snoop is about to write or invalidate a line.
module mesi_snoop
  import mesi_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       snoop_valid,
  input  logic [2:0] snoop_cmd,
  input  logic       snoop_tag_match,
  input  logic [1:0] snoop_state,
  output logic       snoop_state_we,
  output logic [1:0] snoop_state_out,
  output logic       snoop_flush,
  output logic       snoop_we_next,
  output logic       same_line_inv
);

  logic   snoop_we_q,    snoop_we_d;
  state_t snoop_out_q,   snoop_out_d;
  logic   snoop_flush_q, snoop_flush_d;
  state_t cur_state;
  bus_cmd_t cur_cmd;

  assign cur_state = state_t'(snoop_state);
  assign cur_cmd   = bus_cmd_t'(snoop_cmd);

  always_comb begin
    snoop_we_d    = 1'b0;
    snoop_out_d   = snoop_out_q;
    snoop_flush_d = 1'b0;
    same_line_inv = 1'b0;
    if (snoop_valid && snoop_tag_match) begin
      case (cur_cmd)
        bus_read: begin
          if (cur_state == M || cur_state == E) begin
            snoop_we_d    = 1'b1;
            snoop_out_d   = S;
            snoop_flush_d = (cur_state == M);
          end
        end
        bus_readex, bus_upgrade: begin
          // Flagged even for I so a pending upgrade is always demoted.
          same_line_inv = 1'b1;
          if (cur_state != I) begin
            snoop_we_d    = 1'b1;
            snoop_out_d   = I;
            snoop_flush_d = (cur_state == M);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snoop_we_q    <= 1'b0;
      snoop_out_q   <= I;
      snoop_flush_q <= 1'b0;
    end else begin
      snoop_we_q    <= snoop_we_d;
      snoop_out_q   <= snoop_out_d;
      snoop_flush_q <= snoop_flush_d;
    end
  end

  assign snoop_state_we  = snoop_we_q;
  assign snoop_state_out = snoop_out_q;
  assign snoop_flush     = snoop_flush_q;
  assign snoop_we_next   = snoop_we_d;

endmodule

// File: rtl/mesi_controller.sv
// Per-cache MESI/MSI coherence controller: hit classification, bus
// request/grant sequencing with dirty-victim writeback, snoop responses.
module mesi_controller
  import mesi_controller_pkg::*;
#(
  parameter bit MESI_EN = 1'b1,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_valid,
  input  logic               cpu_store,
  input  logic               tag_match,
  input  logic [1:0]         line_state,
  output logic               cpu_ready,
  output logic               cpu_hit,
  output logic               state_we,
  output logic [1:0]         state_out,
  output logic               bus_req,
  input  logic               bus_gnt,
  output logic [2:0]         bus_cmd,
  input  logic               bus_done,
  input  logic               bus_shared,
  input  logic               snoop_valid,
  input  logic [2:0]         snoop_cmd,
  input  logic               snoop_tag_match,
  input  logic [1:0]         snoop_state,
  output logic               snoop_state_we,
  output logic [1:0]         snoop_state_out,
  output logic               snoop_flush,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count,
  output logic [COUNT_W-1:0] wb_count
);

  fsm_t     fsm_q,       fsm_d;
  bus_cmd_t fill_cmd_q,  fill_cmd_d;
  logic     store_q,     store_d;
  logic     shared_q,    shared_d;
  logic     cpu_ready_q, cpu_ready_d;
  logic     cpu_hit_q,   cpu_hit_d;
  logic     state_we_q,  state_we_d;
  state_t   state_out_q, state_out_d;
  logic [NUM_CNT-1:0] cnt_inc;
  logic [COUNT_W-1:0] cnt_val [NUM_CNT];

  logic   snoop_we_next, same_line_inv;
  state_t cur_state;
  logic   line_hit, accept;

  mesi_snoop u_snoop (
    .clk             (clk),
    .reset           (reset),
    .snoop_valid     (snoop_valid),
    .snoop_cmd       (snoop_cmd),
    .snoop_tag_match (snoop_tag_match),
    .snoop_state     (snoop_state),
    .snoop_state_we  (snoop_state_we),
    .snoop_state_out (snoop_state_out),
    .snoop_flush     (snoop_flush),
    .snoop_we_next   (snoop_we_next),
    .same_line_inv   (same_line_inv)
  );

  assign cur_state = state_t'(line_state);
  assign line_hit  = tag_match && (cur_state != I);
  // Skip the cycle where cpu_ready is still up (request not yet dropped) and
  // any cycle where a snoop write is pending, so line_state is never stale.
  assign accept    = cpu_valid && !cpu_ready_q && !snoop_we_next && !snoop_state_we;

  always_comb begin
    fsm_d       = fsm_q;
    fill_cmd_d  = fill_cmd_q;
    store_d     = store_q;
    shared_d    = shared_q;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = 1'b0;
    state_we_d  = 1'b0;
    state_out_d = state_out_q;
    cnt_inc     = '0;
    case (fsm_q)
      FSM_IDLE: begin
        if (accept) begin
          if (line_hit && !(cpu_store && cur_state == S)) begin
            cpu_ready_d      = 1'b1;
            cpu_hit_d        = 1'b1;
            cnt_inc[CNT_HIT] = 1'b1;
            if (cpu_store && cur_state == E) begin
              state_we_d  = 1'b1;
              state_out_d = M;
            end
          end else begin
            cnt_inc[CNT_MISS] = 1'b1;
            store_d           = cpu_store;
            if (line_hit) begin
              fill_cmd_d = bus_upgrade;
              fsm_d      = FSM_ARB_FILL;
            end else begin
              fill_cmd_d = cpu_store ? bus_readex : bus_read;
              fsm_d      = (cur_state == M) ? FSM_ARB_WB : FSM_ARB_FILL;
            end
          end
        end
      end
      FSM_ARB_WB: begin
        if (bus_gnt) begin
          fsm_d           = FSM_WB;
          cnt_inc[CNT_WB] = 1'b1;
        end
      end
      FSM_WB: begin
        if (bus_done) fsm_d = FSM_ARB_FILL;
      end
      FSM_ARB_FILL: begin
        // Another cache took ownership first; our S copy is gone, so the
        // upgrade must become a full read-exclusive.
        if (bus_gnt) fsm_d = FSM_FILL;
        else if (same_line_inv && fill_cmd_q == bus_upgrade) fill_cmd_d = bus_readex;
      end
      FSM_FILL: begin
        if (bus_done) begin
          shared_d = bus_shared;
          fsm_d    = FSM_DONE;
        end
      end
      FSM_DONE: begin
        if (!snoop_we_next) begin
          cpu_ready_d = 1'b1;
          state_we_d  = 1'b1;
          state_out_d = store_q ? M : ((MESI_EN && !shared_q) ? E : S);
          fsm_d       = FSM_IDLE;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= FSM_IDLE;
      fill_cmd_q  <= bus_none;
      store_q     <= 1'b0;
      shared_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_hit_q   <= 1'b0;
      state_we_q  <= 1'b0;
      state_out_q <= I;
    end else begin
      fsm_q       <= fsm_d;
      fill_cmd_q  <= fill_cmd_d;
      store_q     <= store_d;
      shared_q    <= shared_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      state_we_q  <= state_we_d;
      state_out_q <= state_out_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [COUNT_W-1:0] cnt_q, cnt_d;
      always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc[gi] && (cnt_q != {COUNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
      end
      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
      assign cnt_val[gi] = cnt_q;
    end
  endgenerate

  always_comb begin
    bus_cmd = bus_none;
    case (fsm_q)
      FSM_ARB_WB, FSM_WB:     bus_cmd = bus_flush;
      FSM_ARB_FILL, FSM_FILL: bus_cmd = fill_cmd_q;
      default:                bus_cmd = bus_none;
    endcase
  end

  assign bus_req    = (fsm_q == FSM_ARB_WB) || (fsm_q == FSM_WB) ||
                      (fsm_q == FSM_ARB_FILL) || (fsm_q == FSM_FILL);
  assign cpu_ready  = cpu_ready_q;
  assign cpu_hit    = cpu_hit_q;
  assign state_we   = state_we_q;
  assign state_out  = state_out_q;
  assign hit_count  = cnt_val[CNT_HIT];
  assign miss_count = cnt_val[CNT_MISS];
  assign wb_count   = cnt_val[CNT_WB];

endmodule

// File: tb/tb_mesi_controller.sv
// Directed bench: a MESI instance and an MSI instance with 2-bit counters
// run in lockstep on the same stimulus.
module tb_mesi_controller;

  logic clk = 1'b0;
  logic reset, cpu_valid, cpu_store, tag_match, bus_gnt, bus_done, bus_shared;
  logic snoop_valid, snoop_tag_match;
  logic [1:0] line_state, snoop_state;
  logic [2:0] snoop_cmd;

  logic cpu_ready, cpu_hit, state_we, bus_req, snoop_state_we, snoop_flush;
  logic [1:0] state_out, snoop_state_out;
  logic [2:0] bus_cmd;
  logic [31:0] hit_count, miss_count, wb_count;

  logic m_cpu_ready, m_cpu_hit, m_state_we, m_bus_req, m_snoop_state_we, m_snoop_flush;
  logic [1:0] m_state_out, m_snoop_state_out;
  logic [2:0] m_bus_cmd;
  logic [1:0] m_hit_count, m_miss_count, m_wb_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mesi_controller #(.MESI_EN(1'b1), .COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_store(cpu_store),
    .tag_match(tag_match), .line_state(line_state), .cpu_ready(cpu_ready),
    .cpu_hit(cpu_hit), .state_we(state_we), .state_out(state_out),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_done(bus_done),
    .bus_shared(bus_shared), .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd),
    .snoop_tag_match(snoop_tag_match), .snoop_state(snoop_state),
    .snoop_state_we(snoop_state_we), .snoop_state_out(snoop_state_out),
    .snoop_flush(snoop_flush), .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
  );

  mesi_controller #(.MESI_EN(1'b0), .COUNT_W(2)) dut_msi (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_store(cpu_store),
    .tag_match(tag_match), .line_state(line_state), .cpu_ready(m_cpu_ready),
    .cpu_hit(m_cpu_hit), .state_we(m_state_we), .state_out(m_state_out),
    .bus_req(m_bus_req), .bus_gnt(bus_gnt), .bus_cmd(m_bus_cmd), .bus_done(bus_done),
    .bus_shared(bus_shared), .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd),
    .snoop_tag_match(snoop_tag_match), .snoop_state(snoop_state),
    .snoop_state_we(m_snoop_state_we), .snoop_state_out(m_snoop_state_out),
    .snoop_flush(m_snoop_flush), .hit_count(m_hit_count), .miss_count(m_miss_count),
    .wb_count(m_wb_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic v, input logic st, input logic tm, input logic [1:0] ls);
    cpu_valid = v; cpu_store = st; tag_match = tm; line_state = ls;
  endtask

  task automatic set_snoop(input logic v, input logic [2:0] cmd, input logic tm, input logic [1:0] ss);
    snoop_valid = v; snoop_cmd = cmd; snoop_tag_match = tm; snoop_state = ss;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; bus_gnt = 1'b0; bus_done = 1'b0; bus_shared = 1'b0;
    set_cpu(1'b0, 1'b0, 1'b0, 2'd0);
    set_snoop(1'b0, 3'd0, 1'b0, 2'd0);
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_state_out", {30'd0, state_out}, 32'd0);
    chk("rst_snoop_out", {30'd0, snoop_state_out}, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);

    // Load hit on S
    set_cpu(1'b1, 1'b0, 1'b1, 2'd1);
    tick();
    chk("ld_hit_ready", {31'd0, cpu_ready}, 32'd1);
    chk("ld_hit_hit", {31'd0, cpu_hit}, 32'd1);
    chk("ld_hit_we", {31'd0, state_we}, 32'd0);
    chk("ld_hit_count", hit_count, 32'd1);
    chk("ld_hit_busreq", {31'd0, bus_req}, 32'd0);
    set_cpu(1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk("ld_hit_ready_drop", {31'd0, cpu_ready}, 32'd0);

    // Store hit on E: silent upgrade
    set_cpu(1'b1, 1'b1, 1'b1, 2'd2);
    tick();
    chk("st_e_we", {31'd0, state_we}, 32'd1);
    chk("st_e_state", {30'd0, state_out}, 32'd3);
    chk("st_e_ready", {31'd0, cpu_ready}, 32'd1);
    chk("st_e_busreq", {31'd0, bus_req}, 32'd0);
    set_cpu(1'b0, 1'b0, 1'b0, 2'd0);
    tick();

    // Load miss with dirty victim: writeback then read
    set_cpu(1'b1, 1'b0, 1'b0, 2'd3);
    tick();
    chk("wb_req", {31'd0, bus_req}, 32'd1);
    chk("wb_cmd_flush", {29'd0, bus_cmd}, 32'd4);
    chk("wb_miss_count", miss_count, 32'd1);
    tick();
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    chk("wb_count", wb_count, 32'd1);
    chk("wb_cmd_hold", {29'd0, bus_cmd}, 32'd4);
    tick(); tick();
    bus_done = 1'b1; tick(); bus_done = 1'b0;
    chk("fill_req", {31'd0, bus_req}, 32'd1);
    chk("fill_cmd_read", {29'd0, bus_cmd}, 32'd1);
    tick(); tick();
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    chk("fill_cmd_hold", {29'd0, bus_cmd}, 32'd1);
    tick(); tick();
    bus_done = 1'b1; bus_shared = 1'b0; tick(); bus_done = 1'b0;
    chk("done_busreq", {31'd0, bus_req}, 32'd0);
    tick();
    chk("miss_ready", {31'd0, cpu_ready}, 32'd1);
    chk("miss_hit", {31'd0, cpu_hit}, 32'd0);
    chk("miss_we", {31'd0, state_we}, 32'd1);
    chk("miss_state_e", {30'd0, state_out}, 32'd2);
    chk("msi_state_s", {30'd0, m_state_out}, 32'd1);
    chk("miss_wb_count", wb_count, 32'd1);
    chk("miss_miss_count", miss_count, 32'd1);
    set_cpu(1'b0, 1'b0, 1'b0, 2'd0);
    tick();

    // Store on S; a snoop readex on the same line wins the race for the bus
    set_cpu(1'b1, 1'b1, 1'b1, 2'd1);
    tick();
    chk("upg_cmd", {29'd0, bus_cmd}, 32'd3);
    chk("upg_miss_count", miss_count, 32'd2);
    set_snoop(1'b1, 3'd2, 1'b1, 2'd1);
    tick();
    set_snoop(1'b0, 3'd0, 1'b0, 2'd0);
    chk("race_snoop_we", {31'd0, snoop_state_we}, 32'd1);
    chk("race_snoop_out", {30'd0, snoop_state_out}, 32'd0);
    chk("race_snoop_flush", {31'd0, snoop_flush}, 32'd0);
    chk("race_cmd_readex", {29'd0, bus_cmd}, 32'd2);
    tick();
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    chk("race_cmd_issued", {29'd0, bus_cmd}, 32'd2);
    bus_done = 1'b1; bus_shared = 1'b1; tick(); bus_done = 1'b0; bus_shared = 1'b0;
    // Snoop hit lands while in DONE: the CPU-side write slips one cycle
    set_snoop(1'b1, 3'd1, 1'b1, 2'd2);
    tick();
    set_snoop(1'b0, 3'd0, 1'b0, 2'd0);
    chk("stall_we", {31'd0, state_we}, 32'd0);
    chk("stall_ready", {31'd0, cpu_ready}, 32'd0);
    chk("stall_snoop_we", {31'd0, snoop_state_we}, 32'd1);
    chk("stall_snoop_out", {30'd0, snoop_state_out}, 32'd1);
    tick();
    chk("race_ready", {31'd0, cpu_ready}, 32'd1);
    chk("race_we", {31'd0, state_we}, 32'd1);
    chk("race_state_m", {30'd0, state_out}, 32'd3);
    set_cpu(1'b0, 1'b0, 1'b0, 2'd0);
    tick();

    // Snoop bus_read on M while idle
    set_snoop(1'b1, 3'd1, 1'b1, 2'd3);
    tick();
    chk("snp_rd_we", {31'd0, snoop_state_we}, 32'd1);
    chk("snp_rd_out", {30'd0, snoop_state_out}, 32'd1);
    chk("snp_rd_flush", {31'd0, snoop_flush}, 32'd1);
    // Non-matching tag and bus_flush produce no write
    set_snoop(1'b1, 3'd2, 1'b0, 2'd3);
    tick();
    chk("snp_nomatch_we", {31'd0, snoop_state_we}, 32'd0);
    set_snoop(1'b1, 3'd4, 1'b1, 2'd3);
    tick();
    chk("snp_flushcmd_we", {31'd0, snoop_state_we}, 32'd0);
    chk("snp_flushcmd_flush", {31'd0, snoop_flush}, 32'd0);
    set_snoop(1'b1, 3'd2, 1'b1, 2'd3);
    tick();
    set_snoop(1'b0, 3'd0, 1'b0, 2'd0);
    chk("snp_rdx_m_out", {30'd0, snoop_state_out}, 32'd0);
    chk("snp_rdx_m_flush", {31'd0, snoop_flush}, 32'd1);
    tick();

    // Three more load hits: 2-bit counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      set_cpu(1'b1, 1'b0, 1'b1, 2'd3);
      tick();
      set_cpu(1'b0, 1'b0, 1'b0, 2'd0);
      tick();
    end
    chk("hit_count_5", hit_count, 32'd5);
    chk("msi_hit_sat", {30'd0, m_hit_count}, 32'd3);

    // Reset while in WB
    set_cpu(1'b1, 1'b0, 1'b0, 2'd3);
    tick();
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
    chk("mid_rst_cmd", {29'd0, bus_cmd}, 32'd0);
    chk("mid_rst_we", {31'd0, state_we}, 32'd0);
    chk("mid_rst_hits", hit_count, 32'd0);
    chk("mid_rst_miss", miss_count, 32'd0);
    chk("mid_rst_wb", wb_count, 32'd0);
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk("post_rst_req", {31'd0, bus_req}, 32'd0);
    chk("post_rst_ready", {31'd0, cpu_ready}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
